// File: rtl/demux_1to4_buffered.sv
// Registered 1-to-4 demultiplexer: one valid/ready input stream is steered to one of four
// single-entry output buffers, chosen by Selector or by a round-robin pointer.
module demux_1to4_buffered #(
    parameter int WORD_LENGTH = 8,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Auto_Mode,
    input  logic [1:0]             Selector,
    input  logic [WORD_LENGTH-1:0] In_Data,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    output logic [WORD_LENGTH-1:0] Out_Data0,
    output logic [WORD_LENGTH-1:0] Out_Data1,
    output logic [WORD_LENGTH-1:0] Out_Data2,
    output logic [WORD_LENGTH-1:0] Out_Data3,
    output logic [3:0]             Out_Valid,
    input  logic [3:0]             Out_Ready,
    output logic [1:0]             Rr_Pointer,
    output logic [CNT_WIDTH-1:0]   Word_Count0,
    output logic [CNT_WIDTH-1:0]   Word_Count1,
    output logic [CNT_WIDTH-1:0]   Word_Count2,
    output logic [CNT_WIDTH-1:0]   Word_Count3
);

    logic [WORD_LENGTH-1:0] data_q [4];
    logic [CNT_WIDTH-1:0]   cnt_q  [4];
    logic [3:0]             full_q;
    logic [1:0]             ptr_q;
    logic [1:0]             sel;
    logic                   accept;
    logic [3:0]             load;
    logic [3:0]             drain;

    // A full buffer can still take a new word in the same cycle its consumer drains it.
    assign sel      = Auto_Mode ? ptr_q : Selector;
    assign In_Ready = ~full_q[sel] | Out_Ready[sel];
    assign accept   = In_Valid & In_Ready;
    assign load     = accept ? (4'b0001 << sel) : 4'b0000;
    assign drain    = full_q & Out_Ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 4'b0000;
            ptr_q  <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_q[i] <= In_Data;
                    full_q[i] <= 1'b1;
                    cnt_q[i]  <= cnt_q[i] + CNT_WIDTH'(1);
                end else if (drain[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
            if (accept && Auto_Mode) begin
                ptr_q <= ptr_q + 2'd1;
            end
        end
    end

    assign Out_Valid   = full_q;
    assign Rr_Pointer  = ptr_q;
    assign Out_Data0   = data_q[0];
    assign Out_Data1   = data_q[1];
    assign Out_Data2   = data_q[2];
    assign Out_Data3   = data_q[3];
    assign Word_Count0 = cnt_q[0];
    assign Word_Count1 = cnt_q[1];
    assign Word_Count2 = cnt_q[2];
    assign Word_Count3 = cnt_q[3];

endmodule

// File: tb/tb_demux_1to4_buffered.sv
// Directed bench for demux_1to4_buffered: a table of hand-computed cycles plus
// sequences for reset, counter wrap and asynchronous mid-transfer reset.
module tb_demux_1to4_buffered;

    localparam int WL = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          auto_mode = 1'b0;
    logic [1:0]    selector = 2'd0;
    logic [WL-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WL-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready = 4'b0000;
    logic [1:0]    rr_pointer;
    logic [CW-1:0] word_count0, word_count1, word_count2, word_count3;

    int vec_count = 0;
    int miscompares = 0;

    demux_1to4_buffered #(.WORD_LENGTH(WL), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .Auto_Mode   (auto_mode),
        .Selector    (selector),
        .In_Data     (in_data),
        .In_Valid    (in_valid),
        .In_Ready    (in_ready),
        .Out_Data0   (out_data0),
        .Out_Data1   (out_data1),
        .Out_Data2   (out_data2),
        .Out_Data3   (out_data3),
        .Out_Valid   (out_valid),
        .Out_Ready   (out_ready),
        .Rr_Pointer  (rr_pointer),
        .Word_Count0 (word_count0),
        .Word_Count1 (word_count1),
        .Word_Count2 (word_count2),
        .Word_Count3 (word_count3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          auto_mode;
        logic [1:0]    selector;
        logic [WL-1:0] data;
        logic          in_valid;
        logic [3:0]    out_ready;
        logic          exp_ready;
        logic [3:0]    exp_valid;
        logic [1:0]    exp_ptr;
        logic [1:0]    chk_ch;
        logic [WL-1:0] exp_data;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t vecs [26];

    function automatic logic [WL-1:0] data_of(input logic [1:0] ch);
        case (ch)
            2'd0:    return out_data0;
            2'd1:    return out_data1;
            2'd2:    return out_data2;
            default: return out_data3;
        endcase
    endfunction

    function automatic logic [CW-1:0] count_of(input logic [1:0] ch);
        case (ch)
            2'd0:    return word_count0;
            2'd1:    return word_count1;
            2'd2:    return word_count2;
            default: return word_count3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " valid"}, 32'(out_valid), 32'h0);
        check({tag, " ptr"}, 32'(rr_pointer), 32'h0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("%s data%0d", tag, c), 32'(data_of(2'(c))), 32'h0);
            check($sformatf("%s count%0d", tag, c), 32'(count_of(2'(c))), 32'h0);
        end
    endtask

    task automatic drive(input logic am, input logic [1:0] sl, input logic [WL-1:0] d,
                         input logic iv, input logic [3:0] orr);
        auto_mode = am;
        selector  = sl;
        in_data   = d;
        in_valid  = iv;
        out_ready = orr;
    endtask

    task automatic apply_stimulus(input int idx, input vec_t v);
        @(negedge clk);
        drive(v.auto_mode, v.selector, v.data, v.in_valid, v.out_ready);
        #1;
        check($sformatf("v%0d ready", idx), 32'(in_ready), 32'(v.exp_ready));
        @(posedge clk);
        #1;
        check($sformatf("v%0d valid", idx), 32'(out_valid), 32'(v.exp_valid));
        check($sformatf("v%0d ptr", idx), 32'(rr_pointer), 32'(v.exp_ptr));
        check($sformatf("v%0d data%0d", idx, v.chk_ch), 32'(data_of(v.chk_ch)), 32'(v.exp_data));
        check($sformatf("v%0d count%0d", idx, v.chk_ch), 32'(count_of(v.chk_ch)), 32'(v.exp_cnt));
    endtask

    task automatic cycle(input logic am, input logic [1:0] sl, input logic [WL-1:0] d,
                         input logic iv, input logic [3:0] orr);
        @(negedge clk);
        drive(am, sl, d, iv, orr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //         auto sel data   iv  oready  rdy valid   ptr ch data   cnt
        // explicit routing, consumers always ready
        vecs[0]  = '{1'b0, 2'd2, 8'hA0, 1'b1, 4'b1111, 1'b1, 4'b0100, 2'd0, 2'd2, 8'hA0, 8'd1};
        vecs[1]  = '{1'b0, 2'd0, 8'hA1, 1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 2'd0, 8'hA1, 8'd1};
        vecs[2]  = '{1'b0, 2'd3, 8'hA2, 1'b1, 4'b1111, 1'b1, 4'b1000, 2'd0, 2'd3, 8'hA2, 8'd1};
        vecs[3]  = '{1'b0, 2'd1, 8'hA3, 1'b1, 4'b1111, 1'b1, 4'b0010, 2'd0, 2'd1, 8'hA3, 8'd1};
        vecs[4]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 2'd2, 8'hA0, 8'd1};
        // round-robin de-interleave of 0x10..0x17
        vecs[5]  = '{1'b1, 2'd0, 8'h10, 1'b1, 4'b1111, 1'b1, 4'b0001, 2'd1, 2'd0, 8'h10, 8'd2};
        vecs[6]  = '{1'b1, 2'd0, 8'h11, 1'b1, 4'b1111, 1'b1, 4'b0010, 2'd2, 2'd1, 8'h11, 8'd2};
        vecs[7]  = '{1'b1, 2'd0, 8'h12, 1'b1, 4'b1111, 1'b1, 4'b0100, 2'd3, 2'd2, 8'h12, 8'd2};
        vecs[8]  = '{1'b1, 2'd0, 8'h13, 1'b1, 4'b1111, 1'b1, 4'b1000, 2'd0, 2'd3, 8'h13, 8'd2};
        vecs[9]  = '{1'b1, 2'd0, 8'h14, 1'b1, 4'b1111, 1'b1, 4'b0001, 2'd1, 2'd0, 8'h14, 8'd3};
        vecs[10] = '{1'b1, 2'd0, 8'h15, 1'b1, 4'b1111, 1'b1, 4'b0010, 2'd2, 2'd1, 8'h15, 8'd3};
        vecs[11] = '{1'b1, 2'd0, 8'h16, 1'b1, 4'b1111, 1'b1, 4'b0100, 2'd3, 2'd2, 8'h16, 8'd3};
        vecs[12] = '{1'b1, 2'd0, 8'h17, 1'b1, 4'b1111, 1'b1, 4'b1000, 2'd0, 2'd3, 8'h17, 8'd3};
        vecs[13] = '{1'b1, 2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 2'd3, 8'h17, 8'd3};
        // backpressure on channel 1, then same-cycle drain and refill
        vecs[14] = '{1'b0, 2'd1, 8'h55, 1'b1, 4'b0000, 1'b1, 4'b0010, 2'd0, 2'd1, 8'h55, 8'd4};
        vecs[15] = '{1'b0, 2'd1, 8'h66, 1'b1, 4'b0000, 1'b0, 4'b0010, 2'd0, 2'd1, 8'h55, 8'd4};
        vecs[16] = '{1'b0, 2'd1, 8'h66, 1'b1, 4'b0000, 1'b0, 4'b0010, 2'd0, 2'd1, 8'h55, 8'd4};
        vecs[17] = '{1'b0, 2'd1, 8'h66, 1'b1, 4'b0010, 1'b1, 4'b0010, 2'd0, 2'd1, 8'h66, 8'd5};
        vecs[18] = '{1'b0, 2'd1, 8'h00, 1'b0, 4'b0000, 1'b0, 4'b0010, 2'd0, 2'd1, 8'h66, 8'd5};
        // channel 0 drains while channel 3 is loaded on the same edge
        vecs[19] = '{1'b0, 2'd0, 8'h70, 1'b1, 4'b0000, 1'b1, 4'b0011, 2'd0, 2'd0, 8'h70, 8'd4};
        vecs[20] = '{1'b0, 2'd3, 8'h77, 1'b1, 4'b0001, 1'b1, 4'b1010, 2'd0, 2'd3, 8'h77, 8'd4};
        // pointer holds on stall and across mode changes
        vecs[21] = '{1'b1, 2'd3, 8'h80, 1'b1, 4'b0000, 1'b1, 4'b1011, 2'd1, 2'd0, 8'h80, 8'd5};
        vecs[22] = '{1'b1, 2'd0, 8'h81, 1'b1, 4'b0000, 1'b0, 4'b1011, 2'd1, 2'd1, 8'h66, 8'd5};
        vecs[23] = '{1'b0, 2'd2, 8'h90, 1'b1, 4'b0000, 1'b1, 4'b1111, 2'd1, 2'd2, 8'h90, 8'd4};
        vecs[24] = '{1'b1, 2'd0, 8'h91, 1'b1, 4'b0010, 1'b1, 4'b1111, 2'd2, 2'd1, 8'h91, 8'd6};
        vecs[25] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 2'd2, 2'd0, 8'h80, 8'd5};

        // Hold reset with random inputs toggling; everything must stay cleared.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
            #1;
            check_cleared($sformatf("reset%0d", k));
        end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
        #1;
        check("ready after reset", 32'(in_ready), 32'h1);

        for (int i = 0; i < 26; i++) begin
            apply_stimulus(i, vecs[i]);
        end

        // Channel 2 count is 4 here; 251 more accepts reach 255, one more wraps to 0.
        for (int k = 0; k < 251; k++) begin
            cycle(1'b0, 2'd2, 8'(k), 1'b1, 4'b1111);
        end
        check("count2 at 255", 32'(word_count2), 32'hFF);
        cycle(1'b0, 2'd2, 8'hEE, 1'b1, 4'b1111);
        check("count2 wrap", 32'(word_count2), 32'h0);
        check("data2 wrap", 32'(out_data2), 32'hEE);
        check("valid wrap", 32'(out_valid), 32'b0100);

        // Build Out_Valid=1011, then reset between edges without a clock.
        cycle(1'b0, 2'd0, 8'h00, 1'b0, 4'b1111);
        cycle(1'b0, 2'd0, 8'hC0, 1'b1, 4'b0000);
        cycle(1'b0, 2'd1, 8'hC1, 1'b1, 4'b0000);
        cycle(1'b0, 2'd3, 8'hC3, 1'b1, 4'b0000);
        check("prefill valid", 32'(out_valid), 32'b1011);
        check("prefill ptr", 32'(rr_pointer), 32'h2);
        check("prefill data3", 32'(out_data3), 32'hC3);
        #2;
        reset = 1'b0;
        #1;
        check_cleared("async reset");
        #10;
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
